// File: rtl/charge_pkg.sv
// Shared types and constants for the charging-kiosk session controller.
//   state_e   : session state encoding
//   BLANK     : money code that blanks the display scanner
//   sat_add   : saturating money accumulate
//   to_time   : money -> charging time conversion
package charge_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned CNT_W      = 8;
   localparam int unsigned COIN1_VAL  = 1;
   localparam int unsigned COIN10_VAL = 10;
   localparam logic [DATA_W-1:0] BLANK = 8'hFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PAY    = 2'd1,
      CHARGE = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Add with a 9-bit intermediate so the clamp sees the true sum.
   function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] lim);
      logic [DATA_W:0] s;
      s = (DATA_W+1)'(a) + (DATA_W+1)'(b);
      return (s > (DATA_W+1)'(lim)) ? lim : s[DATA_W-1:0];
   endfunction

   // Product fits in 8 bits because MAX_MONEY*RATE <= 99 is enforced.
   function automatic logic [DATA_W-1:0] to_time(input logic [DATA_W-1:0] m,
                                                 input logic [DATA_W-1:0] rate);
      return DATA_W'(16'(m) * 16'(rate));
   endfunction

endpackage

// File: rtl/charge_ctrl_if.sv
// Event inputs and display/relay outputs of the session controller.
//   master : stimulus side (drives events, observes outputs)
//   slave  : controller side
interface charge_ctrl_if;
   import charge_pkg::*;

   logic              tick;
   logic              coin1;
   logic              coin10;
   logic              start;
   logic              cancel;
   logic [DATA_W-1:0] money;
   logic [DATA_W-1:0] restime;
   logic              charging;
   logic              done;

   modport master (
      output tick, coin1, coin10, start, cancel,
      input  money, restime, charging, done
   );

   modport slave (
      input  tick, coin1, coin10, start, cancel,
      output money, restime, charging, done
   );

endinterface

// File: rtl/edge_rise.sv
// Rising-edge detector for a debounced level.
//   CLK, RST_N : clock, synchronous active-low reset
//   d          : level input
//   pulse      : one-cycle high on a 0->1 transition of d
module edge_rise (
   input  logic CLK,
   input  logic RST_N,
   input  logic d,
   output logic pulse
);

   logic q;

   // q keeps sampling d during reset: a level held high across reset release
   // is never an event, and with idle inputs q is 0 coming out of reset.
   always_ff @(posedge CLK) begin
      q <= d;
   end

   assign pulse = d & ~q & RST_N;

endmodule

// File: rtl/charge_ctrl.sv
// Kiosk session controller: accumulates coins, converts to time, counts down
// on the 1 Hz tick and drives the money/restime display pair.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus.tick   : 1 Hz strobe;  bus.coin1/coin10/start/cancel : debounced levels
//   bus.money  : paid amount (8'hFF = blank);  bus.restime : remaining time
//   bus.charging / bus.done : high in CHARGE / DONE
module charge_ctrl
   import charge_pkg::*;
#(
   parameter int unsigned MAX_MONEY   = 20,
   parameter int unsigned RATE        = 2,
   parameter int unsigned PAY_TIMEOUT = 10,
   parameter int unsigned DONE_HOLD   = 3
) (
   input  logic          CLK,
   input  logic          RST_N,
   charge_ctrl_if.slave  bus
);

   if (MAX_MONEY < 1 || MAX_MONEY > 99 || MAX_MONEY * RATE > 99) begin : g_bad_params
      $error("charge_ctrl: MAX_MONEY must be 1..99 and MAX_MONEY*RATE <= 99");
   end

   localparam logic [DATA_W-1:0] MAX_L  = DATA_W'(MAX_MONEY);
   localparam logic [DATA_W-1:0] RATE_L = DATA_W'(RATE);
   localparam logic [CNT_W-1:0]  PT_L   = CNT_W'(PAY_TIMEOUT);
   localparam logic [CNT_W-1:0]  DH_L   = CNT_W'(DONE_HOLD);

   logic coin1_ev, coin10_ev, start_ev, cancel_ev, coin_ev;
   logic [DATA_W-1:0] coin_val;

   edge_rise u_edge_coin1  (.CLK(CLK), .RST_N(RST_N), .d(bus.coin1),  .pulse(coin1_ev));
   edge_rise u_edge_coin10 (.CLK(CLK), .RST_N(RST_N), .d(bus.coin10), .pulse(coin10_ev));
   edge_rise u_edge_start  (.CLK(CLK), .RST_N(RST_N), .d(bus.start),  .pulse(start_ev));
   edge_rise u_edge_cancel (.CLK(CLK), .RST_N(RST_N), .d(bus.cancel), .pulse(cancel_ev));

   // Both coins on one edge add 11.
   assign coin_ev  = coin1_ev | coin10_ev;
   assign coin_val = (coin1_ev  ? DATA_W'(COIN1_VAL)  : '0)
                   + (coin10_ev ? DATA_W'(COIN10_VAL) : '0);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] money_q, money_d;
   logic [DATA_W-1:0] restime_q, restime_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              charging_q, done_q;

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         money_q    <= BLANK;
         restime_q  <= '0;
         cnt_q      <= '0;
         charging_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         money_q    <= money_d;
         restime_q  <= restime_d;
         cnt_q      <= cnt_d;
         charging_q <= (state_d == CHARGE);
         done_q     <= (state_d == DONE);
      end
   end

   // Next state and next output values; cancel > start > coins.
   always_comb begin
      logic [CNT_W-1:0] cnt_inc;
      state_d   = state_q;
      money_d   = money_q;
      restime_d = restime_q;
      cnt_d     = cnt_q;
      cnt_inc   = cnt_q + CNT_W'(1);

      unique case (state_q)
         IDLE: begin
            if (coin_ev) begin
               state_d   = PAY;
               money_d   = sat_add('0, coin_val, MAX_L);
               restime_d = to_time(money_d, RATE_L);
            end
         end
         PAY: begin
            if (cancel_ev) begin
               state_d   = IDLE;
               money_d   = BLANK;
               restime_d = '0;
            end else if (start_ev) begin
               state_d = CHARGE;
            end else if (coin_ev) begin
               money_d   = sat_add(money_q, coin_val, MAX_L);
               restime_d = to_time(money_d, RATE_L);
               cnt_d     = '0;
            end else if (bus.tick) begin
               cnt_d = cnt_inc;
               if (cnt_inc >= PT_L) begin
                  state_d   = IDLE;
                  money_d   = BLANK;
                  restime_d = '0;
               end
            end
         end
         CHARGE: begin
            if (cancel_ev) begin
               state_d   = DONE;
               money_d   = '0;
               restime_d = '0;
            end else if (bus.tick) begin
               if (restime_q <= DATA_W'(1)) begin
                  state_d   = DONE;
                  money_d   = '0;
                  restime_d = '0;
               end else begin
                  restime_d = restime_q - DATA_W'(1);
               end
            end
         end
         DONE: begin
            if (bus.tick) begin
               cnt_d = cnt_inc;
               if (cnt_inc >= DH_L) begin
                  state_d   = IDLE;
                  money_d   = BLANK;
                  restime_d = '0;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            money_d   = BLANK;
            restime_d = '0;
         end
      endcase

      // A new state always starts its tick count from zero.
      if (state_d != state_q) cnt_d = '0;
   end

   assign bus.money    = money_q;
   assign bus.restime  = restime_q;
   assign bus.charging = charging_q;
   assign bus.done     = done_q;

endmodule
